gerador_pulso_botao: RTL and testbench

//   Upstream stage for the 4-bit asynchronous up counter. Turns a raw, bouncing

---
 rtl/gerador_pulso_botao_if.sv | 34 +++
 rtl/gerador_pulso_botao.sv | 147 ++++++++++++++
 tb/tb_gerador_pulso_botao.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/gerador_pulso_botao_if.sv
`default_nettype none
// ============================================================================
//  Module      : gerador_pulso_botao_if
//  Description : Signal bundle between the push-button pulse generator and
//                whatever drives the button / consumes the count pulse.
//                  btn   - raw button level (asynchronous, may bounce)
//                  T     - one-cycle count pulse
//                  held  - debounced button level
//                  state - debug view of the press/release FSM
//                master: drives btn, observes outputs.
//                slave : the pulse generator itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface gerador_pulso_botao_if;
   logic       btn;
   logic       T;
   logic       held;
   logic [1:0] state;

   modport master (
      output btn,
      input  T,
      input  held,
      input  state
   );

   modport slave (
      input  btn,
      output T,
      output held,
      output state
   );
endinterface
`default_nettype wire

// File: rtl/gerador_pulso_botao.sv
`default_nettype none
// ============================================================================
//  Module      : gerador_pulso_botao
//  Description : Turns a raw, bouncing push-button into clean one-cycle count
//                pulses for the downstream ripple counter.
//                Chain: 2-FF synchroniser -> debounce timer -> press/release
//                FSM -> optional auto-repeat.
//  Ports       : clk          rising-edge clock
//                clear        synchronous active-high reset
//                bus.btn      raw button level (in)
//                bus.T        count pulse, one cycle wide (out, registered)
//                bus.held     debounced button level (out, registered)
//                bus.state    FSM state 0 IDLE/1 ARM/2 HELD/3 REL (out)
//  Revision    : 1.0 - initial release
// ============================================================================
module gerador_pulso_botao #(
   parameter int DB_CYCLES    = 4,
   parameter int REPEAT_EN    = 1,
   parameter int REPEAT_DELAY = 16,
   parameter int REPEAT_RATE  = 8,
   parameter int CW           = 8
) (
   input  logic                 clk,
   input  logic                 clear,
   gerador_pulso_botao_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      HELD = 2'd2,
      REL  = 2'd3
   } state_t;

   localparam logic [CW-1:0] DB_LAST   = CW'(DB_CYCLES - 1);
   localparam logic [CW-1:0] RPT_FIRST = CW'(REPEAT_DELAY);
   localparam logic [CW-1:0] RPT_NEXT  = CW'(REPEAT_RATE);

   logic          sync1, sync2;
   state_t        state_reg, state_nxt;
   logic [CW-1:0] db_cnt, db_nxt;
   logic [CW-1:0] rpt_cnt, rpt_nxt;
   logic          rpt_phase, phase_nxt;   // 0: waiting for first repeat, 1: steady rate
   logic          t_reg, t_nxt;
   logic          held_reg, held_nxt;
   logic [CW-1:0] rpt_target;
   logic [CW:0]   rpt_inc;                // one extra bit so the compare never wraps

   assign rpt_target = rpt_phase ? RPT_NEXT : RPT_FIRST;
   assign rpt_inc    = {1'b0, rpt_cnt} + (CW+1)'(1);

   always_ff @(posedge clk) begin
      if (clear) begin
         sync1     <= 1'b0;
         sync2     <= 1'b0;
         state_reg <= IDLE;
         db_cnt    <= '0;
         rpt_cnt   <= '0;
         rpt_phase <= 1'b0;
         t_reg     <= 1'b0;
         held_reg  <= 1'b0;
      end else begin
         sync1     <= bus.btn;
         sync2     <= sync1;
         state_reg <= state_nxt;
         db_cnt    <= db_nxt;
         rpt_cnt   <= rpt_nxt;
         rpt_phase <= phase_nxt;
         t_reg     <= t_nxt;
         held_reg  <= held_nxt;
      end
   end

   always_comb begin
      state_nxt = state_reg;
      db_nxt    = db_cnt;
      rpt_nxt   = rpt_cnt;
      phase_nxt = rpt_phase;
      t_nxt     = 1'b0;
      held_nxt  = held_reg;

      case (state_reg)
         IDLE: begin
            if (sync2) begin
               state_nxt = ARM;
               db_nxt    = CW'(1);
            end
         end

         ARM: begin
            if (!sync2) begin
               state_nxt = IDLE;
            end else if (db_cnt >= DB_LAST) begin
               // ">=" also covers DB_CYCLES=1, where DB_LAST is zero
               state_nxt = HELD;
               t_nxt     = 1'b1;
               held_nxt  = 1'b1;
               rpt_nxt   = '0;
               phase_nxt = 1'b0;
            end else begin
               db_nxt = db_cnt + CW'(1);
            end
         end

         HELD: begin
            if (!sync2) begin
               state_nxt = REL;
               db_nxt    = CW'(1);
            end else if (REPEAT_EN != 0) begin
               if (rpt_inc >= {1'b0, rpt_target}) begin
                  if (!t_reg) begin
                     t_nxt     = 1'b1;
                     rpt_nxt   = '0;
                     phase_nxt = 1'b1;
                  end else begin
                     // Pulse due right after another one: park at the target
                     // and fire next cycle so the ripple counter can settle.
                     rpt_nxt = rpt_target;
                  end
               end else begin
                  rpt_nxt = rpt_inc[CW-1:0];
               end
            end
         end

         REL: begin
            if (sync2) begin
               // Release glitch: back to HELD, repeat timer resumes frozen.
               state_nxt = HELD;
            end else if (db_cnt >= DB_LAST) begin
               state_nxt = IDLE;
               held_nxt  = 1'b0;
            end else begin
               db_nxt = db_cnt + CW'(1);
            end
         end

         default: state_nxt = IDLE;
      endcase
   end

   assign bus.T     = t_reg;
   assign bus.held  = held_reg;
   assign bus.state = state_reg;

endmodule
`default_nettype wire

// File: tb/tb_gerador_pulso_botao.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gerador_pulso_botao
//  Description : Self-checking bench for gerador_pulso_botao. A reference
//                model built on run lengths of the synchronised button
//                predicts pulses (queued by cycle number), the debounced
//                level and the debug state; a monitor compares at negedge.
//                Directed scenarios are followed by random bouncing input.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gerador_pulso_botao;

   localparam int DB    = 4;
   localparam int REP   = 1;
   localparam int DELAY = 16;
   localparam int RATE  = 8;

   logic clk = 1'b0;
   logic clear;
   gerador_pulso_botao_if bus ();

   gerador_pulso_botao #(
      .DB_CYCLES   (DB),
      .REPEAT_EN   (REP),
      .REPEAT_DELAY(DELAY),
      .REPEAT_RATE (RATE),
      .CW          (8)
   ) dut (
      .clk  (clk),
      .clear(clear),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
      end
   endtask

   // ---------------- reference model (runs on posedge) ----------------
   int   cyc     = 0;
   bit   m_valid = 0;
   int   exp_q[$];
   bit   exp_held;
   int   exp_state;

   initial begin
      bit m_s1, m_s2, s, sp, m_held, prev_held, t, t_prev, first;
      int run, ticks;
      m_s1 = 0; m_s2 = 0; sp = 0; m_held = 0; t_prev = 0; first = 1;
      run = 0; ticks = 0; exp_held = 0; exp_state = 0;
      forever begin
         @(posedge clk);
         cyc++;
         if (clear) begin
            m_s1 = 0; m_s2 = 0; sp = 0; m_held = 0; t_prev = 0; first = 1;
            run = 0; ticks = 0; exp_held = 0; exp_state = 0;
            exp_q.delete();
            m_valid = 1;
         end else begin
            // value the FSM sees at this edge was sampled two edges ago
            s    = m_s2;
            m_s2 = m_s1;
            m_s1 = bus.btn;
            t    = 0;
            if (s == sp) run++; else run = 1;
            prev_held = m_held;
            if (s != m_held && run >= DB) m_held = s;
            if (!prev_held && m_held) begin
               t = 1; ticks = 0; first = 1;
            end else if (prev_held && m_held && s && sp) begin
               ticks++;
               if (REP != 0 && ticks >= (first ? DELAY : RATE) && !t_prev) begin
                  t = 1; ticks = 0; first = 0;
               end
            end
            sp        = s;
            t_prev    = t;
            exp_held  = m_held;
            exp_state = m_held ? (s ? 2 : 3) : (s ? 1 : 0);
            if (t) exp_q.push_back(cyc);
         end
      end
   end

   // ---------------- monitor (negedge) ----------------
   initial begin
      forever begin
         @(negedge clk);
         if (m_valid) begin
            while (exp_q.size() > 0 && exp_q[0] < cyc) begin
               checks++; errors++;
               $display("FAIL t_missed: got no pulse expected pulse at cycle %0d", exp_q[0]);
               void'(exp_q.pop_front());
            end
            if (bus.T) begin
               checks++;
               if (exp_q.size() > 0 && exp_q[0] == cyc) void'(exp_q.pop_front());
               else begin
                  errors++;
                  $display("FAIL t_spurious: got pulse at cycle %0d expected none", cyc);
               end
            end
            chk("held_model",  int'(bus.held),  int'(exp_held));
            chk("state_model", int'(bus.state), exp_state);
         end
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   // ---------------- stimulus ----------------
   initial begin
      int npulse, maxst, tseen;
      clear   = 1'b1;
      bus.btn = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_T",     int'(bus.T),     0);
      chk("reset_held",  int'(bus.held),  0);
      chk("reset_state", int'(bus.state), 0);
      clear = 1'b0;
      repeat (3) @(negedge clk);

      // press: pulse on the 6th edge, then auto-repeat while held
      bus.btn = 1'b1;
      repeat (5) @(negedge clk);
      chk("press_T_early", int'(bus.T), 0);
      @(negedge clk);
      chk("press_T",     int'(bus.T),     1);
      chk("press_held",  int'(bus.held),  1);
      chk("press_state", int'(bus.state), 2);
      npulse = 0;
      repeat (44) begin
         @(negedge clk);
         if (bus.T) npulse++;
      end
      chk("repeat_count", npulse, 4);

      // short release glitch keeps held, then a real release
      bus.btn = 1'b0;
      repeat (2) @(negedge clk);
      bus.btn = 1'b1;
      repeat (10) begin
         @(negedge clk);
         chk("glitch_held", int'(bus.held), 1);
      end
      bus.btn = 1'b0;
      repeat (5) @(negedge clk);
      chk("release_held_early", int'(bus.held), 1);
      @(negedge clk);
      chk("release_held",  int'(bus.held),  0);
      chk("release_state", int'(bus.state), 0);
      repeat (4) @(negedge clk);

      // bounce shorter than the debounce window
      bus.btn = 1'b1;
      maxst = 0; tseen = 0;
      repeat (3) begin
         @(negedge clk);
         if (int'(bus.state) > maxst) maxst = int'(bus.state);
         if (bus.T) tseen++;
      end
      bus.btn = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (int'(bus.state) > maxst) maxst = int'(bus.state);
         if (bus.T) tseen++;
      end
      chk("bounce_maxstate", maxst, 1);
      chk("bounce_T",        tseen, 0);
      chk("bounce_held",     int'(bus.held), 0);

      // clear mid-HELD with the button still down
      bus.btn = 1'b1;
      repeat (10) @(negedge clk);
      chk("pre_clear_state", int'(bus.state), 2);
      clear = 1'b1;
      @(negedge clk);
      chk("clear_T",     int'(bus.T),     0);
      chk("clear_held",  int'(bus.held),  0);
      chk("clear_state", int'(bus.state), 0);
      clear = 1'b0;
      repeat (5) @(negedge clk);
      chk("after_clear_T_early", int'(bus.T), 0);
      @(negedge clk);
      chk("after_clear_T", int'(bus.T), 1);
      bus.btn = 1'b0;
      repeat (12) @(negedge clk);

      // random bouncing input with occasional clears
      for (int k = 0; k < 120; k++) begin
         if ($urandom_range(0, 15) == 0) begin
            clear = 1'b1;
            repeat ($urandom_range(1, 2)) @(negedge clk);
            clear = 1'b0;
         end
         bus.btn = 1'($urandom_range(0, 1));
         repeat ($urandom_range(1, 30)) @(negedge clk);
      end
      bus.btn = 1'b0;
      repeat (20) @(negedge clk);
      chk("queue_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
